// File: rtl/ifft_seq.sv
// ifft_seq: sequential radix-2 DIT inverse FFT with one butterfly and a
// register-array frame buffer. Frames are loaded in natural bin order,
// stored bit-reversed, transformed in place and dumped in natural order.
// Optional feature macro: IFFT_SCALE_EN (halve every butterfly output,
// for an overall gain of 1/SIZE).
//
// state  | meaning
// S_LOAD | accept SIZE input bins, write to bitrev(cnt)
// S_CALC | one butterfly per clock, log2(SIZE) stages of SIZE/2
// S_DUMP | present buffer[cnt] on the output stream
module ifft_seq #(
  parameter int SIZE = 16,
  parameter int RN   = 16,
  parameter int FRAC = 14
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0][RN-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0][RN-1:0]  out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int LG  = $clog2(SIZE);
  localparam int PW  = RN + 32;
  // The twiddle table is held at 14 fraction bits and rescaled to FRAC.
  localparam int SHL = (FRAC >= 14) ? FRAC - 14 : 0;
  localparam int SHR = (FRAC < 14) ? 14 - FRAC : 0;
  localparam logic [LG-1:0] LAST      = LG'(SIZE - 1);
  localparam logic [LG-1:0] PRE_LAST  = LG'(SIZE - 2);
  localparam logic [LG-1:0] HALF_LAST = LG'(SIZE / 2 - 1);
  localparam logic [LG-1:0] STG_LAST  = LG'(LG - 1);

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_DUMP} state_t;

  state_t state;
  logic [LG-1:0] cnt, j, stg;
  logic signed [RN-1:0] buf_re [SIZE];
  logic signed [RN-1:0] buf_im [SIZE];

  logic [LG-1:0] h, mask, addr_a, addr_b;
  logic [4:0] tw_m;
  logic signed [31:0] c_re, c_im, w_re, w_im;
  logic signed [PW-1:0] bx_re, bx_im, wx_re, wx_im;
  logic signed [RN-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [RN-1:0] na_re, na_im, nb_re, nb_im;

  function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] v);
    for (int i = 0; i < LG; i++) bitrev[i] = v[LG-1-i];
  endfunction

  // cos(2*pi*m/64) in Q14 for the first quarter wave; 64 points cover every
  // supported SIZE since m = k*64/SIZE.
  function automatic logic signed [31:0] cos_q14(input logic [4:0] idx);
    case (idx)
      5'd0:    cos_q14 = 32'sd16384;
      5'd1:    cos_q14 = 32'sd16305;
      5'd2:    cos_q14 = 32'sd16069;
      5'd3:    cos_q14 = 32'sd15679;
      5'd4:    cos_q14 = 32'sd15137;
      5'd5:    cos_q14 = 32'sd14449;
      5'd6:    cos_q14 = 32'sd13623;
      5'd7:    cos_q14 = 32'sd12665;
      5'd8:    cos_q14 = 32'sd11585;
      5'd9:    cos_q14 = 32'sd10394;
      5'd10:   cos_q14 = 32'sd9102;
      5'd11:   cos_q14 = 32'sd7723;
      5'd12:   cos_q14 = 32'sd6270;
      5'd13:   cos_q14 = 32'sd4756;
      5'd14:   cos_q14 = 32'sd3196;
      5'd15:   cos_q14 = 32'sd1606;
      default: cos_q14 = 32'sd0;
    endcase
  endfunction

  // Butterfly addressing and twiddle lookup; W = exp(+j*2*pi*m/64).
  always_comb begin
    h      = LG'(1) << stg;
    mask   = h - LG'(1);
    addr_a = ((j & ~mask) << 1) | (j & mask);
    addr_b = addr_a | h;
    tw_m   = 5'(j & mask) << (5 - int'(stg));
    if (tw_m <= 5'd16) begin
      c_re = cos_q14(tw_m);
      c_im = cos_q14(5'd16 - tw_m);
    end else begin
      c_re = -cos_q14(5'd0 - tw_m);
      c_im = cos_q14(tw_m - 5'd16);
    end
    w_re = (c_re <<< SHL) >>> SHR;
    w_im = (c_im <<< SHL) >>> SHR;
  end

  // Complex multiply at full width, truncate to RN bits, then add/subtract.
  always_comb begin
    a_re  = buf_re[addr_a];
    a_im  = buf_im[addr_a];
    b_re  = buf_re[addr_b];
    b_im  = buf_im[addr_b];
    bx_re = PW'(b_re);
    bx_im = PW'(b_im);
    wx_re = PW'(w_re);
    wx_im = PW'(w_im);
    t_re  = RN'((bx_re * wx_re - bx_im * wx_im) >>> FRAC);
    t_im  = RN'((bx_re * wx_im + bx_im * wx_re) >>> FRAC);
`ifdef IFFT_SCALE_EN
    na_re = RN'(((RN+1)'(a_re) + (RN+1)'(t_re)) >>> 1);
    na_im = RN'(((RN+1)'(a_im) + (RN+1)'(t_im)) >>> 1);
    nb_re = RN'(((RN+1)'(a_re) - (RN+1)'(t_re)) >>> 1);
    nb_im = RN'(((RN+1)'(a_im) - (RN+1)'(t_im)) >>> 1);
`else
    na_re = a_re + t_re;
    na_im = a_im + t_im;
    nb_re = a_re - t_re;
    nb_im = a_im - t_im;
`endif
  end

  // Frame buffer: bit-reversed load, in-place butterfly writeback.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) begin
      buf_re[bitrev(cnt)] <= in_data[0];
      buf_im[bitrev(cnt)] <= in_data[1];
    end else if (state == S_CALC) begin
      buf_re[addr_a] <= na_re;
      buf_im[addr_a] <= na_im;
      buf_re[addr_b] <= nb_re;
      buf_im[addr_b] <= nb_im;
    end
  end

  // Sequencer with registered stream flags.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= S_LOAD;
      cnt       <= '0;
      j         <= '0;
      stg       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              cnt      <= '0;
              j        <= '0;
              stg      <= '0;
              state    <= S_CALC;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              cnt <= cnt + LG'(1);
            end
          end
        end
        S_CALC: begin
          if (j == HALF_LAST) begin
            j <= '0;
            if (stg == STG_LAST) begin
              stg       <= '0;
              cnt       <= '0;
              state     <= S_DUMP;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
            end else begin
              stg <= stg + LG'(1);
            end
          end else begin
            j <= j + LG'(1);
          end
        end
        S_DUMP: begin
          if (out_ready) begin
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= S_LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              cnt      <= cnt + LG'(1);
              out_last <= (cnt == PRE_LAST);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign out_data[0] = buf_re[cnt];
  assign out_data[1] = buf_im[cnt];

endmodule

// File: tb/tb_ifft_seq.sv
// Directed bench for ifft_seq at SIZE=8; expectations follow IFFT_SCALE_EN.
module tb_ifft_seq;
  localparam int SIZE = 8;
  localparam int RN   = 16;
  localparam int FRAC = 14;
`ifdef IFFT_SCALE_EN
  localparam int AMP   = 1024;
  localparam int DIAG  = 724;
  localparam int ALLB0 = 8192;
`else
  localparam int AMP   = 8192;
  localparam int DIAG  = 5793;
  localparam int ALLB0 = 0;
`endif

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [1:0][RN-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [1:0][RN-1:0] out_data;

  int vectors = 0;
  int errors  = 0;
  int fr_re [SIZE];
  int fr_im [SIZE];
  int got_re [SIZE];
  int got_im [SIZE];
  logic got_last [SIZE];
  int latency;

  // k=1 tone: out[n] = AMP*exp(+j*2*pi*n/8)
  int rot_re [SIZE] = '{AMP, DIAG, 0, -DIAG, -AMP, -DIAG, 0, DIAG};
  int rot_im [SIZE] = '{0, DIAG, AMP, DIAG, 0, -DIAG, -AMP, -DIAG};

  ifft_seq #(.SIZE(SIZE), .RN(RN), .FRAC(FRAC)) dut (
    .clk(clk), .n_reset(n_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_frame(input int kind);
    for (int i = 0; i < SIZE; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
    if (kind == 0) fr_re[0] = 8192;
    else if (kind == 1) fr_re[1] = 8192;
    else for (int i = 0; i < SIZE; i++) fr_re[i] = 8192;
  endtask

  task automatic load_frame();
    for (int i = 0; i < SIZE; i++) begin
      in_valid   = 1'b1;
      in_data[0] = RN'(fr_re[i]);
      in_data[1] = RN'(fr_im[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Counts edges until out_valid; optionally drives junk on in_valid in CALC.
  task automatic wait_out(input bit junk);
    latency = 0;
    while (out_valid !== 1'b1 && latency < 200) begin
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL calc_flags cycle %0d: in_ready=%b busy=%b, want 0/1", latency, in_ready, busy);
      end
      if (junk) begin
        in_valid   = 1'b1;
        in_data[0] = 16'h7abc;
        in_data[1] = 16'h1234;
      end
      @(posedge clk); #1;
      latency++;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic recv_frame(input bit bp);
    logic [1:0][RN-1:0] snap;
    logic snap_last;
    for (int i = 0; i < SIZE; i++) begin
      int guard = 0;
      bit done = 0;
      while (!done) begin
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL dump_flags idx %0d: valid=%b in_ready=%b busy=%b, want 1/0/1", i, out_valid, in_ready, busy);
        end
        snap      = out_data;
        snap_last = out_last;
        out_ready = (bp && guard < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        if (out_ready) begin
          got_re[i]   = int'($signed(snap[0]));
          got_im[i]   = int'($signed(snap[1]));
          got_last[i] = snap_last;
          done = 1;
        end else begin
          vectors++;
          if (out_data !== snap || out_last !== snap_last) begin
            errors++;
            $display("FAIL stall_hold idx %0d: data=%h last=%b, want %h/%b", i, out_data, out_last, snap, snap_last);
          end
        end
        guard++;
      end
    end
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: valid=%b in_ready=%b busy=%b, want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_impulse();
    set_frame(0);
    load_frame();
    wait_out(1'b0);
    vectors++;
    if (latency !== 12) begin errors++; $display("FAIL impulse_latency got %0d want 12", latency); end
    recv_frame(1'b0);
    for (int i = 0; i < SIZE; i++) begin
      vectors++;
      if (got_re[i] !== AMP || got_im[i] !== 0 || got_last[i] !== (i == SIZE - 1)) begin
        errors++;
        $display("FAIL impulse[%0d] got (%0d,%0d) last=%b want (%0d,0) last=%b", i, got_re[i], got_im[i], got_last[i], AMP, (i == SIZE - 1));
      end
    end
  endtask

  task automatic test_rotation(input bit bp);
    set_frame(1);
    load_frame();
    wait_out(bp);
    recv_frame(bp);
    for (int i = 0; i < SIZE; i++) begin
      int dr = got_re[i] - rot_re[i];
      int di = got_im[i] - rot_im[i];
      vectors++;
      if (dr > 2 || dr < -2 || di > 2 || di < -2 || got_last[i] !== (i == SIZE - 1)) begin
        errors++;
        $display("FAIL rotation%s[%0d] got (%0d,%0d) last=%b want (%0d,%0d)+-2 last=%b", bp ? "_bp" : "", i, got_re[i], got_im[i], got_last[i], rot_re[i], rot_im[i], (i == SIZE - 1));
      end
    end
  endtask

  task automatic test_wrap();
    set_frame(2);
    load_frame();
    wait_out(1'b0);
    recv_frame(1'b0);
    for (int i = 0; i < SIZE; i++) begin
      int er = (i == 0) ? ALLB0 : 0;
      vectors++;
      if (got_re[i] !== er || got_im[i] !== 0) begin
        errors++;
        $display("FAIL allbins[%0d] got (%0d,%0d) want (%0d,0)", i, got_re[i], got_im[i], er);
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    set_frame(0);
    load_frame();
    repeat (5) @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_reset: valid=%b in_ready=%b busy=%b, want 0/1/0", out_valid, in_ready, busy);
    end
    #1 n_reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midcalc_after: valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    test_impulse();
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_rotation(1'b0);
    test_wrap();
    test_rotation(1'b1);
    test_reset_mid_calc();
    test_impulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
